// File: rtl/traffic_phase_scheduler.sv
// Four-approach traffic phase scheduler: GREEN -> YELLOW -> ALL_RED cycle with
// round-robin service of latched requests, min/max green and emergency preemption.
module traffic_phase_scheduler #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned HOME      = 0
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic [3:0] req,
  input  logic       emerg,
  input  logic [1:0] emerg_dir,
  output logic [7:0] lights,
  output logic [1:0] active,
  output logic [1:0] phase,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  localparam logic [CNT_W-1:0] MIN_M1    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX = {CNT_W{1'b1}};
  localparam logic [1:0]       HOME_A    = 2'(HOME);

  localparam logic [1:0] LC_RED    = 2'd0;
  localparam logic [1:0] LC_YELLOW = 2'd1;
  localparam logic [1:0] LC_GREEN  = 2'd2;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       active_q, active_d;
  logic [3:0]       pending_q, pending_d;

  logic [1:0] sel;
  logic       rr_found;
  logic       other;
  logic       emerg_away;

  // Grant selection for the next green: emergency, then round-robin after active, then HOME.
  always_comb begin
    sel      = HOME_A;
    rr_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!rr_found && pending_q[2'(active_q + 2'(k))]) begin
        sel      = 2'(active_q + 2'(k));
        rr_found = 1'b1;
      end
    end
    if (emerg) begin
      sel = emerg_dir;
    end
  end

  assign emerg_away = emerg && (emerg_dir != active_q);
  assign other      = ((pending_q & ~(4'b0001 << active_q)) != 4'b0000) || emerg_away;

  // Phase sequencing, timer and request latching.
  always_comb begin
    phase_d   = phase_q;
    active_d  = active_q;
    pending_d = pending_q | req;
    timer_d   = (timer_q == TIMER_MAX) ? timer_q : timer_q + CNT_W'(1);

    case (phase_q)
      PH_ALL_RED: begin
        if (timer_q == ALLRED_M1) begin
          phase_d        = PH_GREEN;
          active_d       = sel;
          pending_d[sel] = 1'b0;
        end
      end
      PH_GREEN: begin
        pending_d[active_q] = 1'b0;
        if (emerg_away) begin
          phase_d = PH_YELLOW;
        end else if (!emerg && other && (timer_q >= MIN_M1) &&
                     (!req[active_q] || (timer_q >= MAX_M1))) begin
          phase_d = PH_YELLOW;
        end
      end
      PH_YELLOW: begin
        if (timer_q == YELLOW_M1) begin
          phase_d = PH_ALL_RED;
        end
      end
      default: begin
        phase_d = PH_ALL_RED;
      end
    endcase

    if (phase_d != phase_q) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      phase_q   <= PH_ALL_RED;
      timer_q   <= '0;
      active_q  <= HOME_A;
      pending_q <= 4'b0000;
    end else begin
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  // Light codes depend only on phase and active, so only one head can be non-red.
  always_comb begin
    lights = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (active_q == 2'(i)) begin
        if (phase_q == PH_GREEN) begin
          lights[2*i +: 2] = LC_GREEN;
        end else if (phase_q == PH_YELLOW) begin
          lights[2*i +: 2] = LC_YELLOW;
        end else begin
          lights[2*i +: 2] = LC_RED;
        end
      end
    end
  end

  assign active  = active_q;
  assign phase   = phase_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: rest on HOME, demand service,
// max-green, round-robin, emergency preemption and mid-yellow reset.
module tb_traffic_phase_scheduler;

  logic       clock = 1'b0;
  logic       clear_n;
  logic [3:0] req;
  logic       emerg;
  logic [1:0] emerg_dir;
  logic [7:0] lights;
  logic [1:0] active;
  logic [1:0] phase;
  logic [3:0] pending;

  int vectors     = 0;
  int miscompares = 0;
  int n;

  always #5 clock = ~clock;

  traffic_phase_scheduler dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .req       (req),
    .emerg     (emerg),
    .emerg_dir (emerg_dir),
    .lights    (lights),
    .active    (active),
    .phase     (phase),
    .pending   (pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int non_red_count(input logic [7:0] l);
    int c = 0;
    for (int i = 0; i < 4; i++) begin
      if (l[2*i +: 2] != 2'd0) c++;
    end
    return c;
  endfunction

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    chk("one_non_red", 32'(non_red_count(lights) <= 1), 32'd1);
  endtask

  // Count consecutive cycles spent in phase p, starting with the current one.
  task automatic measure(input logic [1:0] p, output int cnt);
    cnt = 0;
    while (phase === p && cnt < 300) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    clear_n   = 1'b0;
    req       = 4'b0000;
    emerg     = 1'b0;
    emerg_dir = 2'd0;
    tick();
    tick();
    chk("reset_lights",  32'(lights),  32'h00);
    chk("reset_phase",   32'(phase),   32'd0);
    chk("reset_active",  32'(active),  32'd0);
    chk("reset_pending", 32'(pending), 32'd0);

    // Rest on HOME after two all-red cycles.
    clear_n = 1'b1;
    tick();
    chk("allred_after_reset", 32'(lights), 32'h00);
    chk("allred_phase",       32'(phase),  32'd0);
    tick();
    chk("home_green", 32'(lights), 32'h02);
    chk("home_phase", 32'(phase),  32'd1);
    repeat (50) begin
      tick();
      chk("rest_green", 32'({phase, lights}), 32'({2'd1, 8'h02}));
    end

    // One-cycle request on approach 2 while 0 rests.
    req = 4'b0100;
    tick();
    req = 4'b0000;
    chk("s2_pending", 32'(pending), 32'b0100);
    chk("s2_still_green", 32'(lights), 32'h02);
    tick();
    chk("s2_yellow0", 32'(lights), 32'h01);
    measure(2'd2, n); chk("s2_yellow_len", 32'(n), 32'd3);
    measure(2'd0, n); chk("s2_allred_len", 32'(n), 32'd2);
    chk("s2_green2",   32'(lights),  32'h20);
    chk("s2_active",   32'(active),  32'd2);
    chk("s2_pend_clr", 32'(pending), 32'd0);

    // Reach approach 1, then hold req[1] against a req[3] to hit max green.
    req = 4'b0010;
    measure(2'd1, n); chk("s3_green2_len", 32'(n), 32'd5);
    measure(2'd2, n); chk("s3_yellow_len", 32'(n), 32'd3);
    measure(2'd0, n); chk("s3_allred_len", 32'(n), 32'd2);
    chk("s3_green1", 32'(lights), 32'h08);
    req = 4'b1010;
    measure(2'd1, n); chk("s3_max_green_len", 32'(n), 32'd20);
    chk("s3_yellow1", 32'(lights), 32'h04);
    measure(2'd2, n); chk("s3_yellow_len2", 32'(n), 32'd3);
    measure(2'd0, n); chk("s3_allred_len2", 32'(n), 32'd2);
    chk("s3_green3",  32'(lights), 32'h80);
    chk("s3_active3", 32'(active), 32'd3);

    // Move to approach 0 (wraps ahead of leftover pending[1]).
    req = 4'b0001;
    tick();
    req = 4'b0000;
    measure(2'd1, n); chk("s4_green3_len", 32'(n + 1), 32'd5);
    measure(2'd2, n);
    measure(2'd0, n);
    chk("s4_active0", 32'(active), 32'd0);
    chk("s4_green0",  32'(lights), 32'h02);

    // Round-robin 1, 2, 3 with requests dropped.
    req = 4'b1110;
    tick();
    req = 4'b0000;
    chk("s4_pending", 32'(pending), 32'b1110);
    measure(2'd1, n); chk("s4_green0_len", 32'(n + 1), 32'd5);
    measure(2'd2, n); measure(2'd0, n);
    chk("s4_grant1", 32'({active, phase}), 32'({2'd1, 2'd1}));
    measure(2'd1, n); chk("s4_green1_len", 32'(n), 32'd5);
    measure(2'd2, n); measure(2'd0, n);
    chk("s4_grant2", 32'({active, phase}), 32'({2'd2, 2'd1}));
    measure(2'd1, n); chk("s4_green2_len", 32'(n), 32'd5);
    measure(2'd2, n); measure(2'd0, n);
    chk("s4_grant3",   32'({active, phase}), 32'({2'd3, 2'd1}));
    chk("s4_pend_empty", 32'(pending), 32'd0);
    repeat (10) tick();
    chk("s4_rest3", 32'(lights), 32'h80);

    // Emergency pulse forces 3 off; with nothing pending the grant goes HOME.
    emerg     = 1'b1;
    emerg_dir = 2'd1;
    tick();
    emerg = 1'b0;
    chk("s4_emerg_yellow3", 32'(lights), 32'h40);
    measure(2'd2, n); chk("s4_yellow_len", 32'(n), 32'd3);
    measure(2'd0, n); chk("s4_allred_len", 32'(n), 32'd2);
    chk("s4_home", 32'({active, lights}), 32'({2'd0, 8'h02}));

    // Emergency toward 2 at green timer 1.
    tick();
    emerg     = 1'b1;
    emerg_dir = 2'd2;
    measure(2'd1, n); chk("s5_green_len", 32'(n + 1), 32'd2);
    chk("s5_yellow0", 32'(lights), 32'h01);
    measure(2'd2, n); chk("s5_yellow_len", 32'(n), 32'd3);
    measure(2'd0, n); chk("s5_allred_len", 32'(n), 32'd2);
    chk("s5_green2", 32'(lights), 32'h20);
    req = 4'b1011;
    tick();
    req = 4'b0000;
    chk("s5_pending", 32'(pending), 32'b1011);
    repeat (45) begin
      tick();
      chk("s5_hold", 32'({phase, active}), 32'({2'd1, 2'd2}));
    end
    chk("s5_pending_kept", 32'(pending), 32'b1011);

    // Release emergency, reach approach 3, reset during its yellow.
    emerg = 1'b0;
    tick();
    chk("s6_yellow2", 32'(lights), 32'h10);
    measure(2'd2, n);
    measure(2'd0, n);
    chk("s6_green3", 32'(lights), 32'h80);
    measure(2'd1, n); chk("s6_green3_len", 32'(n), 32'd5);
    tick();
    chk("s6_yellow3", 32'(lights), 32'h40);
    clear_n = 1'b0;
    tick();
    chk("s6_rst_lights",  32'(lights),  32'h00);
    chk("s6_rst_phase",   32'(phase),   32'd0);
    chk("s6_rst_active",  32'(active),  32'd0);
    chk("s6_rst_pending", 32'(pending), 32'd0);
    clear_n = 1'b1;
    tick();
    chk("s6_allred", 32'(lights), 32'h00);
    tick();
    chk("s6_home_green", 32'(lights), 32'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
